shift_decode_stage: RTL and testbench
=====================================

SHIFT_DECODE_STAGE -- requirements
Module: shift_decode_stage

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, setting the width of the discarded-instruction counter.
REQ-002 The block SHALL have input clk, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have input rst_n, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have input InValid, 1 bit, meaning upstream offers an instruction.
REQ-005 The block SHALL have output InReady, 1 bit, meaning the block accepts the offer this cycle.
REQ-006 The block SHALL have input Instr, 32 bits, the MIPS32 instruction word.
REQ-007 The block SHALL have inputs RsData and RtData, 32 bits each, the register-file read values for rs and rt.
REQ-008 The block SHALL have input Flush, 1 bit, a synchronous pipeline kill.
REQ-009 The block SHALL have output OutValid, 1 bit, meaning a decoded shift is presented downstream.
REQ-010 The block SHALL have input OutReady, 1 bit, meaning downstream consumes this cycle.
REQ-011 The block SHALL have outputs Data (32 bits), SRO (2 bits) and SA (5 bits), driven straight into the shifter operand ports.
REQ-012 The block SHALL have output DestReg, 5 bits, the rd field of the shift.
REQ-013 The block SHALL have output DropCnt, CNT_W bits, counting discarded instructions.

Function
REQ-014 The block SHALL accept an instruction when InValid and InReady are both 1; it is an accept.
REQ-015 The block SHALL classify a word as a shift if Instr[31:26]=0 and Instr[5:0] is 000000 (SLL), 000010 (SRL), 000011 (SRA), 000100 (SLLV), 000110 (SRLV) or 000111 (SRAV).
REQ-016 The block SHALL encode SRO as 00 for SLL/SLLV, 01 for SRL/SRLV, and 10 for SRA/SRAV; 11 is never produced.
REQ-017 The block SHALL set SA to Instr[10:6] for SLL/SRL/SRA and to RsData[4:0] for the variable forms.
REQ-018 The block SHALL set Data to RtData and DestReg to Instr[15:11].
REQ-019 The block SHALL discard an accepted word that is not a shift, or that equals 0x00000000 (NOP); DropCnt SHALL increment by 1 and saturate at all-ones.
REQ-020 The block SHALL buffer accepted shifts in a 2-entry buffer: an output register (OR) and a skid register (SK).
REQ-021 An accepted shift SHALL go to OR if OR is empty or is consumed this cycle, and to SK otherwise.
REQ-022 When OR is consumed while SK is full, SK SHALL move to OR in the same edge and an accept that cycle SHALL go to SK.
REQ-023 Latency SHALL be exactly 1 cycle from accept to OutValid when OR is empty.
REQ-024 InReady SHALL be a registered signal equal to (SK empty) and SHALL NOT depend combinationally on InValid or OutReady.
REQ-025 Data, SRO, SA and DestReg SHALL hold stable while OutValid=1 and OutReady=0.
REQ-026 On Flush=1, both entries SHALL be emptied at the next edge, any same-cycle accept SHALL be dropped without counting, and DropCnt SHALL be kept.
REQ-027 When Flush, accept and consume coincide, Flush SHALL win.
REQ-028 Order SHALL be preserved; no shift is lost or duplicated except by Flush.

Reset
REQ-029 While rst_n=0, the block SHALL asynchronously force OutValid=0, InReady=1, Data=0, SRO=00, SA=0, DestReg=0, DropCnt=0 and both entries empty.
REQ-030 After rst_n deasserts, the first accept SHALL occur no earlier than the first rising clk edge.
REQ-031 Reset asserted mid-transfer SHALL discard all buffered content.

Verification
REQ-032 The bench SHALL check: Instr=0x00094100, RtData=0x0000000F, accept -> next cycle OutValid=1, Data=0x0000000F, SRO=00, SA=4, DestReg=8.
REQ-033 The bench SHALL check: Instr=0x01494007, RsData=0x00000023, RtData=0x80000000 -> SRO=10, SA=3, Data=0x80000000, DestReg=8.
REQ-034 The bench SHALL check: OutReady=0 and 3 back-to-back offers -> 2 accepted, InReady=0 from the cycle after the second; on OutReady=1, outputs drain in order and the third is then accepted.
REQ-035 The bench SHALL check: Instr=0x00000000 then 0x01095020 (ADD) -> no OutValid, DropCnt=2; 300 non-shift words with CNT_W=8 -> DropCnt=255.
REQ-036 The bench SHALL check: both entries full plus Flush=1 with InValid=1 -> next cycle OutValid=0 and InReady=1, and the flushed offer never appears.
REQ-037 The bench SHALL check: rst_n pulsed low between clock edges while OutValid=1 -> OutValid=0 immediately and all outputs zero.

Source files
------------

// File: rtl/shift_decode_stage.sv
// Decodes MIPS32 shift instructions into shifter operands behind a 2-entry skid buffer.
// Latency 1 cycle; InReady is registered (SK empty), so upstream backpressure never depends on OutReady combinationally.
module shift_decode_stage #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [31:0]      Instr,
  input  logic [31:0]      RsData,
  input  logic [31:0]      RtData,
  input  logic             Flush,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [31:0]      Data,
  output logic [1:0]       SRO,
  output logic [4:0]       SA,
  output logic [4:0]       DestReg,
  output logic [CNT_W-1:0] DropCnt
);

  localparam int PW = 44;  // {Data, SRO, SA, DestReg}

  logic             or_vld_q, or_vld_d;
  logic             sk_vld_q, sk_vld_d;
  logic [PW-1:0]    or_pl_q, or_pl_d;
  logic [PW-1:0]    sk_pl_q, sk_pl_d;
  logic             in_rdy_q, in_rdy_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic             is_shift;
  logic             var_form;
  logic [1:0]       sro_n;
  logic [4:0]       sa_n;
  logic [PW-1:0]    new_pl;
  logic             accept;
  logic             keep;
  logic             discard;
  logic             consume;
  logic             or_free;

  always_comb begin
    is_shift = 1'b0;
    var_form = 1'b0;
    sro_n    = 2'b00;
    if (Instr[31:26] == 6'b000000) begin
      case (Instr[5:0])
        6'b000000: begin is_shift = 1'b1; sro_n = 2'b00; end
        6'b000010: begin is_shift = 1'b1; sro_n = 2'b01; end
        6'b000011: begin is_shift = 1'b1; sro_n = 2'b10; end
        6'b000100: begin is_shift = 1'b1; sro_n = 2'b00; var_form = 1'b1; end
        6'b000110: begin is_shift = 1'b1; sro_n = 2'b01; var_form = 1'b1; end
        6'b000111: begin is_shift = 1'b1; sro_n = 2'b10; var_form = 1'b1; end
        default:   begin is_shift = 1'b0; end
      endcase
    end
  end

  assign sa_n    = var_form ? RsData[4:0] : Instr[10:6];
  assign new_pl  = {RtData, sro_n, sa_n, Instr[15:11]};
  assign accept  = InValid & in_rdy_q;
  // The all-zero word decodes as SLL but is a NOP and must not reach the shifter.
  assign keep    = accept & is_shift & (Instr != 32'h0000_0000);
  assign discard = accept & ~keep & ~Flush;
  assign consume = or_vld_q & OutReady;
  assign or_free = ~or_vld_q | consume;

  always_comb begin
    or_vld_d = or_vld_q;
    sk_vld_d = sk_vld_q;
    or_pl_d  = or_pl_q;
    sk_pl_d  = sk_pl_q;
    drop_d   = drop_q;
    if (discard && (drop_q != {CNT_W{1'b1}})) begin
      drop_d = drop_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    if (Flush) begin
      or_vld_d = 1'b0;
      sk_vld_d = 1'b0;
    end else if (or_free) begin
      if (sk_vld_q) begin
        or_vld_d = 1'b1;
        or_pl_d  = sk_pl_q;
        sk_vld_d = keep;
        if (keep) begin
          sk_pl_d = new_pl;
        end
      end else begin
        or_vld_d = keep;
        if (keep) begin
          or_pl_d = new_pl;
        end
      end
    end else if (keep) begin
      sk_vld_d = 1'b1;
      sk_pl_d  = new_pl;
    end
    in_rdy_d = ~sk_vld_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_vld_q <= 1'b0;
      sk_vld_q <= 1'b0;
      or_pl_q  <= '0;
      sk_pl_q  <= '0;
      in_rdy_q <= 1'b1;
      drop_q   <= '0;
    end else begin
      or_vld_q <= or_vld_d;
      sk_vld_q <= sk_vld_d;
      or_pl_q  <= or_pl_d;
      sk_pl_q  <= sk_pl_d;
      in_rdy_q <= in_rdy_d;
      drop_q   <= drop_d;
    end
  end

  assign InReady  = in_rdy_q;
  assign OutValid = or_vld_q;
  assign Data     = or_pl_q[43:12];
  assign SRO      = or_pl_q[11:10];
  assign SA       = or_pl_q[9:5];
  assign DestReg  = or_pl_q[4:0];
  assign DropCnt  = drop_q;

endmodule

// File: tb/tb_shift_decode_stage.sv
// Directed bench for shift_decode_stage: decode, skid backpressure, flush, drop counting, async reset.
module tb_shift_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        InValid;
  logic        InReady;
  logic [31:0] Instr;
  logic [31:0] RsData;
  logic [31:0] RtData;
  logic        Flush;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] Data;
  logic [1:0]  SRO;
  logic [4:0]  SA;
  logic [4:0]  DestReg;
  logic [7:0]  DropCnt;

  int checks;
  int errors;

  localparam logic [31:0] ADD_W = 32'h0109_5020;

  shift_decode_stage #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .InValid(InValid), .InReady(InReady),
    .Instr(Instr), .RsData(RsData), .RtData(RtData), .Flush(Flush),
    .OutValid(OutValid), .OutReady(OutReady), .Data(Data), .SRO(SRO),
    .SA(SA), .DestReg(DestReg), .DropCnt(DropCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_sll(input logic [4:0] rd, input logic [4:0] sa);
    return {6'b0, 5'd0, 5'd0, rd, sa, 6'b000000};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; InValid = 1'b0; Instr = '0; RsData = '0; RtData = '0;
    Flush = 1'b0; OutReady = 1'b0;
    #12;
    checks++;
    if (OutValid !== 1'b0 || InReady !== 1'b1 || Data !== 32'h0 || SRO !== 2'b00 ||
        SA !== 5'd0 || DestReg !== 5'd0 || DropCnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: OutValid=%b InReady=%b Data=%h SRO=%b SA=%0d DestReg=%0d DropCnt=%0d required 0 1 0 0 0 0 0",
               OutValid, InReady, Data, SRO, SA, DestReg, DropCnt);
    end
    #2 rst_n = 1'b1;
    step();
  endtask

  task automatic test_decode();
    OutReady = 1'b1;
    InValid = 1'b1; Instr = 32'h0009_4100; RsData = 32'h0; RtData = 32'h0000_000F;
    checks++;
    if (OutValid !== 1'b0) begin
      errors++; $display("FAIL sll_pre_valid: OutValid=%b required 0", OutValid);
    end
    step();
    InValid = 1'b0;
    checks++;
    if (OutValid !== 1'b1 || Data !== 32'h0000_000F || SRO !== 2'b00 || SA !== 5'd4 || DestReg !== 5'd8) begin
      errors++;
      $display("FAIL sll_decode: V=%b Data=%h SRO=%b SA=%0d Dest=%0d required 1 0000000f 00 4 8",
               OutValid, Data, SRO, SA, DestReg);
    end
    InValid = 1'b1; Instr = 32'h0149_4007; RsData = 32'h0000_0023; RtData = 32'h8000_0000;
    step();
    InValid = 1'b0;
    checks++;
    if (OutValid !== 1'b1 || Data !== 32'h8000_0000 || SRO !== 2'b10 || SA !== 5'd3 || DestReg !== 5'd8) begin
      errors++;
      $display("FAIL srav_decode: V=%b Data=%h SRO=%b SA=%0d Dest=%0d required 1 80000000 10 3 8",
               OutValid, Data, SRO, SA, DestReg);
    end
    // SRLV rs=0 rt=0 rd=5: SA from RsData, not from Instr[10:6]=2
    InValid = 1'b1; Instr = 32'h0000_2886; RsData = 32'hFFFF_FF1F; RtData = 32'h1234_5678;
    step();
    InValid = 1'b0;
    checks++;
    if (OutValid !== 1'b1 || Data !== 32'h1234_5678 || SRO !== 2'b01 || SA !== 5'd31 || DestReg !== 5'd5) begin
      errors++;
      $display("FAIL srlv_decode: V=%b Data=%h SRO=%b SA=%0d Dest=%0d required 1 12345678 01 31 5",
               OutValid, Data, SRO, SA, DestReg);
    end
    // SRA rd=7 sa=9: immediate amount despite nonzero RsData
    InValid = 1'b1; Instr = 32'h0000_3A43; RsData = 32'h0000_0011; RtData = 32'hCAFE_0001;
    step();
    InValid = 1'b0;
    checks++;
    if (OutValid !== 1'b1 || Data !== 32'hCAFE_0001 || SRO !== 2'b10 || SA !== 5'd9 || DestReg !== 5'd7) begin
      errors++;
      $display("FAIL sra_decode: V=%b Data=%h SRO=%b SA=%0d Dest=%0d required 1 cafe0001 10 9 7",
               OutValid, Data, SRO, SA, DestReg);
    end
    // SRL rd=3 sa=1
    InValid = 1'b1; Instr = 32'h0000_1842; RsData = 32'h0; RtData = 32'h0000_00AA;
    step();
    InValid = 1'b0;
    checks++;
    if (OutValid !== 1'b1 || SRO !== 2'b01 || SA !== 5'd1 || DestReg !== 5'd3) begin
      errors++;
      $display("FAIL srl_decode: V=%b SRO=%b SA=%0d Dest=%0d required 1 01 1 3", OutValid, SRO, SA, DestReg);
    end
    step();
    checks++;
    if (OutValid !== 1'b0) begin
      errors++; $display("FAIL decode_drain: OutValid=%b required 0", OutValid);
    end
  endtask

  task automatic test_back_to_back();
    OutReady = 1'b0; RsData = '0;
    InValid = 1'b1; Instr = mk_sll(5'd1, 5'd1); RtData = 32'hA;
    step();
    checks++;
    if (OutValid !== 1'b1 || InReady !== 1'b1 || DestReg !== 5'd1) begin
      errors++; $display("FAIL b2b_first: V=%b Rdy=%b Dest=%0d required 1 1 1", OutValid, InReady, DestReg);
    end
    Instr = mk_sll(5'd2, 5'd2); RtData = 32'hB;
    step();
    checks++;
    if (OutValid !== 1'b1 || InReady !== 1'b0 || DestReg !== 5'd1 || Data !== 32'hA) begin
      errors++; $display("FAIL b2b_second: V=%b Rdy=%b Dest=%0d Data=%h required 1 0 1 a", OutValid, InReady, DestReg, Data);
    end
    Instr = mk_sll(5'd3, 5'd3); RtData = 32'hC;
    step();
    checks++;
    if (InReady !== 1'b0 || DestReg !== 5'd1 || SA !== 5'd1 || Data !== 32'hA) begin
      errors++; $display("FAIL b2b_hold: Rdy=%b Dest=%0d SA=%0d Data=%h required 0 1 1 a", InReady, DestReg, SA, Data);
    end
    OutReady = 1'b1;
    step();
    checks++;
    if (OutValid !== 1'b1 || InReady !== 1'b1 || DestReg !== 5'd2 || Data !== 32'hB) begin
      errors++; $display("FAIL b2b_drain1: V=%b Rdy=%b Dest=%0d Data=%h required 1 1 2 b", OutValid, InReady, DestReg, Data);
    end
    step();
    InValid = 1'b0;
    checks++;
    if (OutValid !== 1'b1 || DestReg !== 5'd3 || SA !== 5'd3 || Data !== 32'hC) begin
      errors++; $display("FAIL b2b_drain2: V=%b Dest=%0d SA=%0d Data=%h required 1 3 3 c", OutValid, DestReg, SA, Data);
    end
    step();
    checks++;
    if (OutValid !== 1'b0) begin
      errors++; $display("FAIL b2b_empty: OutValid=%b required 0", OutValid);
    end
  endtask

  task automatic test_flush();
    OutReady = 1'b0;
    InValid = 1'b1; Instr = mk_sll(5'd10, 5'd1); RtData = 32'h10;
    step();
    Instr = mk_sll(5'd11, 5'd2); RtData = 32'h11;
    step();
    Instr = mk_sll(5'd12, 5'd3); RtData = 32'h12; Flush = 1'b1;
    step();
    Flush = 1'b0; InValid = 1'b0;
    checks++;
    if (OutValid !== 1'b0 || InReady !== 1'b1) begin
      errors++; $display("FAIL flush_full: V=%b Rdy=%b required 0 1", OutValid, InReady);
    end
    OutReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (OutValid !== 1'b0) begin
        errors++; $display("FAIL flush_no_ghost: cycle %0d OutValid=%b Dest=%0d required 0", i, OutValid, DestReg);
      end
    end
    // Flush wins over a simultaneous accept and consume; a non-shift accept is not counted.
    InValid = 1'b1; Instr = mk_sll(5'd13, 5'd4); RtData = 32'h13;
    step();
    Instr = ADD_W; Flush = 1'b1;
    step();
    Flush = 1'b0; Instr = mk_sll(5'd14, 5'd5);
    checks++;
    if (OutValid !== 1'b0 || DropCnt !== 8'd0) begin
      errors++; $display("FAIL flush_nonshift: V=%b DropCnt=%0d required 0 0", OutValid, DropCnt);
    end
    Flush = 1'b1;
    step();
    Flush = 1'b0; InValid = 1'b0;
    step();
    checks++;
    if (OutValid !== 1'b0 || DropCnt !== 8'd0) begin
      errors++; $display("FAIL flush_accept: V=%b Dest=%0d DropCnt=%0d required 0 - 0", OutValid, DestReg, DropCnt);
    end
  endtask

  task automatic test_drop();
    OutReady = 1'b1; InValid = 1'b1; Instr = 32'h0000_0000;
    step();
    Instr = ADD_W;
    step();
    InValid = 1'b0;
    checks++;
    if (OutValid !== 1'b0 || DropCnt !== 8'd2) begin
      errors++; $display("FAIL drop_nop_add: V=%b DropCnt=%0d required 0 2", OutValid, DropCnt);
    end
    InValid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      Instr = (i % 2 == 0) ? {6'b100011, 26'(i)} : {26'(i), 6'b100101};
      step();
    end
    InValid = 1'b0;
    step();
    checks++;
    if (OutValid !== 1'b0 || DropCnt !== 8'd255) begin
      errors++; $display("FAIL drop_saturate: V=%b DropCnt=%0d required 0 255", OutValid, DropCnt);
    end
  endtask

  task automatic test_async_reset();
    OutReady = 1'b0; InValid = 1'b1; Instr = mk_sll(5'd9, 5'd6); RtData = 32'hDEAD_BEEF;
    step();
    InValid = 1'b0;
    checks++;
    if (OutValid !== 1'b1 || Data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL pre_reset_valid: V=%b Data=%h required 1 deadbeef", OutValid, Data);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (OutValid !== 1'b0 || InReady !== 1'b1 || Data !== 32'h0 || SRO !== 2'b00 ||
        SA !== 5'd0 || DestReg !== 5'd0 || DropCnt !== 8'd0) begin
      errors++;
      $display("FAIL async_reset: V=%b Rdy=%b Data=%h SRO=%b SA=%0d Dest=%0d Drop=%0d required 0 1 0 0 0 0 0",
               OutValid, InReady, Data, SRO, SA, DestReg, DropCnt);
    end
    step();
    #3 rst_n = 1'b1;
    OutReady = 1'b1;
    step();
    checks++;
    if (OutValid !== 1'b0) begin
      errors++; $display("FAIL reset_discard: OutValid=%b required 0", OutValid);
    end
    InValid = 1'b1; Instr = mk_sll(5'd4, 5'd2); RtData = 32'h5;
    step();
    InValid = 1'b0;
    checks++;
    if (OutValid !== 1'b1 || DestReg !== 5'd4 || SA !== 5'd2 || Data !== 32'h5) begin
      errors++; $display("FAIL post_reset_accept: V=%b Dest=%0d SA=%0d Data=%h required 1 4 2 5", OutValid, DestReg, SA, Data);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_decode();
    test_back_to_back();
    test_flush();
    test_drop();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
